// File: rtl/decode_run_sequencer.sv
// decode_run_sequencer: runs one decode of the generated decoder datapath.
// Captures a syndrome, clears and loads the decoder, steps it until it
// converges or the cycle budget runs out, then reports cycle count and
// timeout through a ready/valid result port. Keeps a saturating run count.
module decode_run_sequencer #(
  parameter int SYNDROME_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      syn_valid,
  output logic                      syn_ready,
  input  logic [SYNDROME_WIDTH-1:0] syn_data,
  output logic                      dec_clear,
  output logic                      dec_load,
  output logic [SYNDROME_WIDTH-1:0] dec_syndrome,
  output logic                      dec_step,
  input  logic                      dec_converged,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [CNT_WIDTH-1:0]      res_cycles,
  output logic                      res_timeout,
  output logic [CNT_WIDTH-1:0]      total_runs,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, REPORT} state_t;

  state_t                    state, state_nxt;
  logic [SYNDROME_WIDTH-1:0] syn_q;
  logic [CNT_WIDTH-1:0]      cyc_cnt;
  logic [CNT_WIDTH-1:0]      runs;
  logic                      tmo_q;

  logic accept, syn_zero, last_cycle, res_hs;

  assign accept     = (state == IDLE) && syn_valid;
  assign syn_zero   = (syn_data == '0);
  // cyc_cnt holds (RUN cycle number - 1) during RUN
  assign last_cycle = (cyc_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign res_hs     = (state == REPORT) && res_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; convergence takes priority over timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = syn_zero ? REPORT : CLEAR;
      CLEAR:   state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (dec_converged || last_cycle) state_nxt = REPORT;
      REPORT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Syndrome capture, RUN cycle counter, timeout flag and run counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syn_q   <= '0;
      cyc_cnt <= '0;
      tmo_q   <= 1'b0;
      runs    <= '0;
    end else begin
      if (accept) begin
        syn_q <= syn_data;
        if (syn_zero) begin
          cyc_cnt <= '0;
          tmo_q   <= 1'b0;
        end
      end
      if (state == LOAD) begin
        cyc_cnt <= '0;
        tmo_q   <= 1'b0;
      end
      if (state == RUN) begin
        cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
        if (!dec_converged && last_cycle) tmo_q <= 1'b1;
      end
      if (res_hs && (runs != '1)) runs <= runs + CNT_WIDTH'(1);
    end
  end

  // Outputs decoded from registered state and datapath registers
  always_comb begin
    syn_ready = (state == IDLE);
    dec_clear = (state == CLEAR);
    dec_load  = (state == LOAD);
    dec_step  = (state == RUN);
    res_valid = (state == REPORT);
    busy      = (state != IDLE);
  end

  assign dec_syndrome = syn_q;
  assign res_cycles   = cyc_cnt;
  assign res_timeout  = tmo_q;
  assign total_runs   = runs;

endmodule

// File: tb/tb_decode_run_sequencer.sv
// Directed bench for decode_run_sequencer: main instance with a 16-cycle
// budget, plus a narrow-counter instance for run-count saturation.
module tb_decode_run_sequencer;

  localparam int SW = 64;

  logic          clk = 0;
  logic          reset = 0;

  // main instance signals
  logic          syn_valid = 0, syn_ready;
  logic [SW-1:0] syn_data = '0, dec_syndrome;
  logic          dec_clear, dec_load, dec_step, dec_converged = 0;
  logic          res_valid, res_ready = 1, res_timeout, busy;
  logic [31:0]   res_cycles, total_runs;

  // saturation instance signals
  logic          b_syn_valid = 0, b_syn_ready;
  logic [SW-1:0] b_syn_data = '0, b_dec_syndrome;
  logic          b_dec_clear, b_dec_load, b_dec_step;
  logic          b_res_valid, b_res_ready = 1, b_res_timeout, b_busy;
  logic [3:0]    b_res_cycles, b_total_runs;

  int checks = 0;
  int errors = 0;
  int exp_runs = 0;

  // event counters sampled on the falling edge
  int n_clear = 0, n_load = 0, n_step = 0;

  always #5 clk = ~clk;

  decode_run_sequencer #(.SYNDROME_WIDTH(SW), .TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_data(syn_data),
    .dec_clear(dec_clear), .dec_load(dec_load), .dec_syndrome(dec_syndrome),
    .dec_step(dec_step), .dec_converged(dec_converged),
    .res_valid(res_valid), .res_ready(res_ready), .res_cycles(res_cycles),
    .res_timeout(res_timeout), .total_runs(total_runs), .busy(busy)
  );

  decode_run_sequencer #(.SYNDROME_WIDTH(SW), .TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset),
    .syn_valid(b_syn_valid), .syn_ready(b_syn_ready), .syn_data(b_syn_data),
    .dec_clear(b_dec_clear), .dec_load(b_dec_load), .dec_syndrome(b_dec_syndrome),
    .dec_step(b_dec_step), .dec_converged(1'b0),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_cycles(b_res_cycles),
    .res_timeout(b_res_timeout), .total_runs(b_total_runs), .busy(b_busy)
  );

  always @(negedge clk) begin
    n_clear <= n_clear + int'(dec_clear);
    n_load  <= n_load  + int'(dec_load);
    n_step  <= n_step  + int'(dec_step);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer a syndrome from IDLE; returns after the accept edge (cycle T+1)
  task automatic offer(input logic [SW-1:0] d);
    syn_valid = 1; syn_data = d;
    tick();
    syn_valid = 0;
  endtask

  // From cycle T+1 of a non-zero run: check clear/load, drive convergence
  // in RUN cycle conv_k (0 = never), return the number of step cycles.
  task automatic finish_run(input int conv_k, output int steps);
    int k;
    checks++;
    if (dec_clear !== 1'b1 || dec_load !== 1'b0) begin
      errors++; $display("FAIL clear_slot: clear=%b load=%b expected 1 0", dec_clear, dec_load);
    end
    tick();
    checks++;
    if (dec_load !== 1'b1 || dec_clear !== 1'b0 || dec_step !== 1'b0) begin
      errors++; $display("FAIL load_slot: load=%b clear=%b step=%b expected 1 0 0", dec_load, dec_clear, dec_step);
    end
    tick();
    k = 1;
    while (dec_step === 1'b1 && k <= 40) begin
      dec_converged = (k == conv_k);
      tick();
      k++;
    end
    dec_converged = 0;
    steps = k - 1;
  endtask

  task automatic check_result(input string nm, input int steps, input int exp_steps,
                              input logic [31:0] exp_cyc, input logic exp_tmo);
    checks++;
    if (steps != exp_steps || res_valid !== 1'b1) begin
      errors++; $display("FAIL %s_steps: steps=%0d res_valid=%b expected %0d 1", nm, steps, res_valid, exp_steps);
    end
    checks++;
    if (res_cycles !== exp_cyc || res_timeout !== exp_tmo) begin
      errors++; $display("FAIL %s_result: cycles=%0d timeout=%b expected %0d %b", nm, res_cycles, res_timeout, exp_cyc, exp_tmo);
    end
  endtask

  task automatic check_handshake(input string nm);
    tick();
    exp_runs++;
    checks++;
    if (syn_ready !== 1'b1 || res_valid !== 1'b0 || total_runs !== 32'(exp_runs)) begin
      errors++; $display("FAIL %s_hs: syn_ready=%b res_valid=%b total_runs=%0d expected 1 0 %0d",
                         nm, syn_ready, res_valid, total_runs, exp_runs);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if (syn_ready !== 1'b1 || busy !== 1'b0 || dec_clear !== 1'b0 || dec_load !== 1'b0 ||
        dec_step !== 1'b0 || res_valid !== 1'b0 || res_timeout !== 1'b0 ||
        dec_syndrome !== '0 || res_cycles !== '0 || total_runs !== '0) begin
      errors++; $display("FAIL %s: ready=%b busy=%b clr=%b ld=%b step=%b rv=%b tmo=%b syn=%h cyc=%0d runs=%0d expected reset values",
                         nm, syn_ready, busy, dec_clear, dec_load, dec_step, res_valid, res_timeout,
                         dec_syndrome, res_cycles, total_runs);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    #3;
    check_reset_vals("reset");
    tick();
    reset = 1;
    tick();
    check_reset_vals("reset_release");
    exp_runs = 0;
  endtask

  task automatic test_basic();
    int steps, c0, l0;
    res_ready = 1;
    c0 = n_clear; l0 = n_load;
    offer(64'h5);
    finish_run(3, steps);
    check_result("basic", steps, 3, 32'd3, 1'b0);
    checks++;
    if (dec_syndrome !== 64'h5 || n_clear - c0 != 1 || n_load - l0 != 1) begin
      errors++; $display("FAIL basic_pulses: syn=%h clears=%0d loads=%0d expected 5 1 1",
                         dec_syndrome, n_clear - c0, n_load - l0);
    end
    check_handshake("basic");
  endtask

  task automatic test_timeout();
    int steps;
    offer(64'hA5);
    finish_run(0, steps);
    check_result("timeout", steps, 16, 32'd16, 1'b1);
    check_handshake("timeout");
  endtask

  task automatic test_conv_last();
    int steps;
    offer(64'h8000_0000_0000_0001);
    finish_run(16, steps);
    check_result("conv_last", steps, 16, 32'd16, 1'b0);
    check_handshake("conv_last");
  endtask

  task automatic test_zero();
    int c0, l0, s0;
    c0 = n_clear; l0 = n_load; s0 = n_step;
    offer('0);
    checks++;
    if (res_valid !== 1'b1 || res_cycles !== '0 || res_timeout !== 1'b0) begin
      errors++; $display("FAIL zero_result: rv=%b cycles=%0d timeout=%b expected 1 0 0", res_valid, res_cycles, res_timeout);
    end
    check_handshake("zero");
    checks++;
    if (n_clear != c0 || n_load != l0 || n_step != s0) begin
      errors++; $display("FAIL zero_activity: clears=%0d loads=%0d steps=%0d expected 0 0 0",
                         n_clear - c0, n_load - l0, n_step - s0);
    end
  endtask

  task automatic test_backpressure();
    int steps;
    int bad = 0;
    res_ready = 0;
    offer(64'h9);
    finish_run(2, steps);
    check_result("bp", steps, 2, 32'd2, 1'b0);
    syn_valid = 1; syn_data = 64'h33;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b1 || res_cycles !== 32'd2 || res_timeout !== 1'b0 || syn_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad);
    end
    res_ready = 1;
    check_handshake("bp");
    tick();
    syn_valid = 0;
    checks++;
    if (dec_syndrome !== 64'h33) begin
      errors++; $display("FAIL bp_next_accept: syn=%h expected 33", dec_syndrome);
    end
    finish_run(1, steps);
    check_result("bp_next", steps, 1, 32'd1, 1'b0);
    check_handshake("bp_next");
  endtask

  task automatic test_reset_mid_run();
    int k;
    offer(64'h7);
    tick();
    tick();
    k = 1;
    while (dec_step === 1'b1 && k < 5) begin
      tick();
      k++;
    end
    checks++;
    if (dec_step !== 1'b1 || k != 5) begin
      errors++; $display("FAIL mid_reach_run5: step=%b k=%0d expected 1 5", dec_step, k);
    end
    reset = 0;
    #1;
    check_reset_vals("mid_reset");
    tick();
    reset = 1;
    exp_runs = 0;
    tick();
    check_reset_vals("mid_release");
    offer(64'h3);
    finish_run(2, k);
    check_result("after_reset", k, 2, 32'd2, 1'b0);
    check_handshake("after_reset");
  endtask

  task automatic test_saturation();
    b_res_ready = 1;
    for (int i = 0; i < 17; i++) begin
      b_syn_valid = 1; b_syn_data = '0;
      tick();
      b_syn_valid = 0;
      tick();
      if (i == 14) begin
        checks++;
        if (b_total_runs !== 4'd15) begin
          errors++; $display("FAIL sat_at15: total_runs=%0d expected 15", b_total_runs);
        end
      end
    end
    checks++;
    if (b_total_runs !== 4'd15 || b_syn_ready !== 1'b1) begin
      errors++; $display("FAIL sat_final: total_runs=%0d ready=%b expected 15 1", b_total_runs, b_syn_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_conv_last();
    test_zero();
    test_backpressure();
    test_reset_mid_run();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
